// File: rtl/red_pitaya_iq_sweep_sequencer_pkg.sv
// red_pitaya_iq_sweep_sequencer_pkg: shared FSM states and default widths for the IQ sweep sequencer
package red_pitaya_iq_sweep_sequencer_pkg;
  localparam int DEF_DATABITS = 18;
  localparam int DEF_ACCBITS = 48;
  localparam int DEF_PHASEBITS = 32;
  localparam int DEF_CNTBITS = 30;
  typedef enum logic [1:0] {IDLE, SETTLE, INTEGRATE, OUTPUT} state_t;
endpackage

// File: rtl/red_pitaya_iq_accumulator.sv
// red_pitaya_iq_accumulator: signed I/Q accumulator pair with clear and enable
// Ports: clk, rst (sync active-high), clr (zeroes both sums, wins over en),
//        en (adds sign-extended i_in/q_in), acc_i/acc_q (running sums).
module red_pitaya_iq_accumulator #(
  parameter int DATABITS = 18,
  parameter int ACCBITS = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [DATABITS-1:0] i_in,
  input  logic signed [DATABITS-1:0] q_in,
  output logic signed [ACCBITS-1:0]  acc_i,
  output logic signed [ACCBITS-1:0]  acc_q
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (en) begin
      acc_i <= acc_i + ACCBITS'(i_in);
      acc_q <= acc_q + ACCBITS'(q_in);
    end
  end
endmodule

// File: rtl/red_pitaya_iq_sweep_sequencer.sv
// red_pitaya_iq_sweep_sequencer: steps an NCO increment over N points, settling then integrating I/Q per point
// Ports: clk_i/rst_i (sync active-high); start_i/abort_i control; points_i, start_inc_i,
//        step_inc_i, settle_cycles_i, avg_cycles_i config latched at start; i_in/q_in samples;
//        phase_inc_o NCO increment; busy_o/done_o status; res_* valid/ready result stream.
module red_pitaya_iq_sweep_sequencer
  import red_pitaya_iq_sweep_sequencer_pkg::*;
#(
  parameter int DATABITS = DEF_DATABITS,
  parameter int ACCBITS = DEF_ACCBITS,
  parameter int PHASEBITS = DEF_PHASEBITS,
  parameter int CNTBITS = DEF_CNTBITS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [15:0]                points_i,
  input  logic [PHASEBITS-1:0]       start_inc_i,
  input  logic [PHASEBITS-1:0]       step_inc_i,
  input  logic [CNTBITS-1:0]         settle_cycles_i,
  input  logic [CNTBITS-1:0]         avg_cycles_i,
  input  logic signed [DATABITS-1:0] i_in,
  input  logic signed [DATABITS-1:0] q_in,
  output logic [PHASEBITS-1:0]       phase_inc_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic signed [ACCBITS-1:0]  res_i_o,
  output logic signed [ACCBITS-1:0]  res_q_o,
  output logic [15:0]                res_index_o
);
  state_t state;
  logic [15:0] idx, pts;
  logic [PHASEBITS-1:0] step;
  logic [CNTBITS-1:0] settle, avg, cnt, last;
  // avg of 0 still integrates one sample
  assign last = (avg == '0) ? '0 : avg - 1'b1;
  assign busy_o = state != IDLE;
  assign res_index_o = idx;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      phase_inc_o <= '0;
      done_o <= 1'b0;
      res_valid_o <= 1'b0;
      idx <= '0;
      pts <= '0;
      step <= '0;
      settle <= '0;
      avg <= '0;
      cnt <= '0;
    end else begin
      done_o <= 1'b0;
      if (state != IDLE && abort_i) begin
        state <= IDLE;
        res_valid_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_i && !abort_i && points_i != '0) begin
            pts <= points_i;
            step <= step_inc_i;
            settle <= settle_cycles_i;
            avg <= avg_cycles_i;
            phase_inc_o <= start_inc_i;
            idx <= '0;
            cnt <= '0;
            state <= SETTLE;
          end
          SETTLE: begin
            cnt <= (cnt == settle) ? '0 : cnt + 1'b1;
            if (cnt == settle) state <= INTEGRATE;
          end
          INTEGRATE: begin
            cnt <= (cnt == last) ? '0 : cnt + 1'b1;
            if (cnt == last) begin
              state <= OUTPUT;
              res_valid_o <= 1'b1;
            end
          end
          OUTPUT: if (res_ready_i) begin
            res_valid_o <= 1'b0;
            if (idx == pts - 16'd1) begin
              state <= IDLE;
              done_o <= 1'b1;
            end else begin
              idx <= idx + 16'd1;
              phase_inc_o <= phase_inc_o + step;
              state <= SETTLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  // sums are cleared throughout SETTLE so INTEGRATE always starts from zero,
  // and hold their value in OUTPUT so the result stays stable under backpressure
  red_pitaya_iq_accumulator #(.DATABITS(DATABITS), .ACCBITS(ACCBITS)) u_acc (
    .clk(clk_i),
    .rst(rst_i),
    .clr(state == SETTLE),
    .en(state == INTEGRATE),
    .i_in(i_in),
    .q_in(q_in),
    .acc_i(res_i_o),
    .acc_q(res_q_o)
  );
endmodule

// File: tb/tb_red_pitaya_iq_sweep_sequencer.sv
// tb_red_pitaya_iq_sweep_sequencer: table, directed and randomized checks against a sweep-level model
module tb_red_pitaya_iq_sweep_sequencer;
  logic clk = 1'b0;
  logic rst_i, start_i, abort_i, res_ready_i;
  logic [15:0] points_i;
  logic [31:0] start_inc_i, step_inc_i;
  logic [29:0] settle_cycles_i, avg_cycles_i;
  logic signed [17:0] i_in, q_in;
  logic [31:0] phase_inc_o;
  logic busy_o, done_o, res_valid_o;
  logic signed [47:0] res_i_o, res_q_o;
  logic [15:0] res_index_o;
  int errors = 0, checks = 0;
  red_pitaya_iq_sweep_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .points_i(points_i), .start_inc_i(start_inc_i), .step_inc_i(step_inc_i),
    .settle_cycles_i(settle_cycles_i), .avg_cycles_i(avg_cycles_i),
    .i_in(i_in), .q_in(q_in), .phase_inc_o(phase_inc_o), .busy_o(busy_o),
    .done_o(done_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_i_o(res_i_o), .res_q_o(res_q_o), .res_index_o(res_index_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int rsamp();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction
  // config changes and stray starts mid-sweep must have no effect
  task automatic scramble(input bit rnd);
    if (rnd) begin
      points_i = 16'($urandom);
      start_inc_i = $urandom;
      step_inc_i = $urandom;
      settle_cycles_i = 30'($urandom);
      avg_cycles_i = 30'($urandom);
      start_i = ($urandom % 6) == 0;
    end
  endtask
  // Model: each point is settle+1 cycles, then N=max(avg,1) summed samples, then
  // an OUTPUT phase ending at the handshake; phase = start + k*step mod 2^32.
  task automatic sweep(input int pts, input logic [31:0] sinc, input logic [31:0] stp,
                       input int settle, input int avg, input bit rnd, input int ci, input int cq,
                       output longint li, output longint lq, output logic [31:0] lph);
    int n, cyc, guard, iv, qv;
    longint si, sq;
    logic [31:0] ph;
    bit rdy;
    n = (avg == 0) ? 1 : avg;
    ph = sinc;
    li = 0; lq = 0; lph = sinc;
    points_i = 16'(pts); start_inc_i = sinc; step_inc_i = stp;
    settle_cycles_i = 30'(settle); avg_cycles_i = 30'(avg);
    start_i = 1'b1; res_ready_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int k = 0; k < pts; k++) begin
      cyc = 0;
      for (int c = 0; c <= settle; c++) begin
        scramble(rnd);
        i_in = 18'(rnd ? rsamp() : ci); q_in = 18'(rnd ? rsamp() : cq);
        tick; cyc++;
        chk("settle_valid", longint'(res_valid_o), 0);
        chk("settle_busy", longint'(busy_o), 1);
        chk("settle_phase", longint'(phase_inc_o), longint'(ph));
      end
      si = 0; sq = 0;
      for (int c = 0; c < n; c++) begin
        scramble(rnd);
        iv = rnd ? rsamp() : ci; qv = rnd ? rsamp() : cq;
        i_in = 18'(iv); q_in = 18'(qv);
        si += iv; sq += qv;
        tick; cyc++;
        if (c < n - 1) chk("integ_valid", longint'(res_valid_o), 0);
      end
      guard = 0;
      do begin
        chk("res_valid", longint'(res_valid_o), 1);
        chk("res_i", longint'(res_i_o), si);
        chk("res_q", longint'(res_q_o), sq);
        chk("res_index", longint'(res_index_o), k);
        chk("out_phase", longint'(phase_inc_o), longint'(ph));
        scramble(rnd);
        rdy = rnd ? (($urandom % 3) != 0) : 1'b1;
        if (guard >= 20) rdy = 1'b1;
        res_ready_i = rdy;
        i_in = 18'(rsamp()); q_in = 18'(rsamp());
        tick; cyc++; guard++;
      end while (!rdy);
      chk("hs_valid", longint'(res_valid_o), 0);
      chk("hs_done", longint'(done_o), longint'(k == pts - 1));
      chk("hs_busy", longint'(busy_o), longint'(k != pts - 1));
      if (!rnd) chk("point_cycles", cyc, settle + n + 2);
      li = si; lq = sq; lph = ph;
      ph = ph + stp;
    end
    start_i = 1'b0; res_ready_i = 1'b1;
    tick;
    chk("idle_done", longint'(done_o), 0);
    chk("idle_busy", longint'(busy_o), 0);
    chk("idle_phase", longint'(phase_inc_o), longint'(lph));
  endtask
  typedef struct {
    int pts; logic [31:0] sinc; logic [31:0] stp; int settle; int avg; int ci; int cq;
    longint ei; longint eq; logic [31:0] elast;
  } vec_t;
  vec_t vecs[4];
  longint li, lq;
  logic [31:0] lph;
  initial begin
    vecs[0] = '{3, 32'd1000, 32'd100, 4, 8, 5, -3, 40, -24, 32'd1200};
    vecs[1] = '{2, 32'hFFFFFF00, 32'h200, 1, 2, 7, 9, 14, 18, 32'h00000100};
    vecs[2] = '{1, 32'd0, 32'd0, 0, 16, -131072, 131071, -2097152, 2097136, 32'd0};
    vecs[3] = '{1, 32'h1234, 32'd5, 2, 0, -131072, 131071, -131072, 131071, 32'h1234};
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; res_ready_i = 1'b1;
    points_i = '0; start_inc_i = '0; step_inc_i = '0; settle_cycles_i = '0; avg_cycles_i = '0;
    i_in = '0; q_in = '0;
    repeat (3) tick;
    rst_i = 1'b0;
    tick;
    chk("rst_busy", longint'(busy_o), 0);
    chk("rst_valid", longint'(res_valid_o), 0);
    chk("rst_done", longint'(done_o), 0);
    chk("rst_phase", longint'(phase_inc_o), 0);
    chk("rst_res_i", longint'(res_i_o), 0);
    chk("rst_index", longint'(res_index_o), 0);
    for (int v = 0; v < 4; v++) begin
      sweep(vecs[v].pts, vecs[v].sinc, vecs[v].stp, vecs[v].settle, vecs[v].avg, 1'b0,
            vecs[v].ci, vecs[v].cq, li, lq, lph);
      chk("tbl_i", li, vecs[v].ei);
      chk("tbl_q", lq, vecs[v].eq);
      chk("tbl_last_phase", longint'(lph), longint'(vecs[v].elast));
    end
    for (int r = 0; r < 8; r++)
      sweep(int'($urandom_range(1, 4)), $urandom, $urandom, int'($urandom_range(0, 5)),
            int'($urandom_range(0, 6)), 1'b1, 0, 0, li, lq, lph);
    // backpressure: result and phase frozen while ready is low
    points_i = 16'd2; start_inc_i = 32'd4000; step_inc_i = 32'd7;
    settle_cycles_i = 30'd1; avg_cycles_i = 30'd2; i_in = 18'sd3; q_in = -18'sd2;
    start_i = 1'b1; tick; start_i = 1'b0;
    repeat (4) tick;
    res_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", longint'(res_valid_o), 1);
      chk("bp_res_i", longint'(res_i_o), 6);
      chk("bp_res_q", longint'(res_q_o), -4);
      chk("bp_phase", longint'(phase_inc_o), 4000);
      chk("bp_index", longint'(res_index_o), 0);
      i_in = 18'(rsamp());
      tick;
    end
    res_ready_i = 1'b1;
    tick;
    chk("bp_hs_valid", longint'(res_valid_o), 0);
    chk("bp_hs_phase", longint'(phase_inc_o), 4007);
    chk("bp_hs_busy", longint'(busy_o), 1);
    abort_i = 1'b1; tick; abort_i = 1'b0;
    chk("ab_settle_busy", longint'(busy_o), 0);
    chk("ab_settle_done", longint'(done_o), 0);
    // abort mid-INTEGRATE, with a simultaneous start
    points_i = 16'd3; start_inc_i = 32'd500; settle_cycles_i = 30'd2; avg_cycles_i = 30'd10;
    start_i = 1'b1; tick; start_i = 1'b0;
    repeat (7) tick;
    chk("ab_pre_busy", longint'(busy_o), 1);
    abort_i = 1'b1; start_i = 1'b1; tick; abort_i = 1'b0; start_i = 1'b0;
    chk("ab_busy", longint'(busy_o), 0);
    chk("ab_valid", longint'(res_valid_o), 0);
    chk("ab_done", longint'(done_o), 0);
    chk("ab_phase", longint'(phase_inc_o), 500);
    tick;
    chk("ab_done2", longint'(done_o), 0);
    chk("ab_busy2", longint'(busy_o), 0);
    // abort together with start in IDLE drops the start
    abort_i = 1'b1; start_i = 1'b1; tick; abort_i = 1'b0; start_i = 1'b0;
    chk("ab_start_busy", longint'(busy_o), 0);
    // reset mid-SETTLE, then a zero-point start
    points_i = 16'd2; start_inc_i = 32'd777; settle_cycles_i = 30'd5; avg_cycles_i = 30'd1;
    start_i = 1'b1; tick; start_i = 1'b0;
    tick; tick;
    rst_i = 1'b1; abort_i = 1'b1; start_i = 1'b1; tick; rst_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
    chk("rs_busy", longint'(busy_o), 0);
    chk("rs_valid", longint'(res_valid_o), 0);
    chk("rs_done", longint'(done_o), 0);
    chk("rs_phase", longint'(phase_inc_o), 0);
    chk("rs_res_i", longint'(res_i_o), 0);
    chk("rs_res_q", longint'(res_q_o), 0);
    chk("rs_index", longint'(res_index_o), 0);
    points_i = 16'd0; start_i = 1'b1; tick; start_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("zero_pts_busy", longint'(busy_o), 0);
      tick;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
